// File: rtl/karat_arb_pkg.sv
// Shared constants, types and the round-robin pick function for the
// karat_mult_arbiter block.
package karat_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned SIZE_IN_DEF = 64;
  localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);

  // Upper bound on requesters the pick function can search.
  localparam int unsigned MAX_REQ  = 64;
  localparam int unsigned MAX_ID_W = 6;

  typedef logic [ID_W_DEF-1:0] req_id_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid, searching ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int unsigned ptr,
                                       input int unsigned n = NUM_REQ_DEF);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !res.found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (valid[j]) begin
          res.found = 1'b1;
          res.idx   = MAX_ID_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/karat_mult.sv
// Combinational one-level Karatsuba multiplier: exact unsigned product of two
// size_in-bit operands using three half-width multiplies.
module karat_mult #(
  parameter int unsigned size_in = 64
) (
  input  logic [size_in-1:0]   a_in,
  input  logic [size_in-1:0]   b_in,
  output logic [2*size_in-1:0] product_out
);

  localparam int unsigned H  = size_in / 2;
  localparam int unsigned HW = 2 * H;
  localparam int unsigned M  = 2 * H + 2;
  localparam int unsigned W  = 2 * size_in;

  logic [H-1:0]  a_lo, a_hi, b_lo, b_hi;
  logic [HW-1:0] z0, z2;
  logic [M-1:0]  sa, sb, z1;

  assign a_lo = a_in[H-1:0];
  assign a_hi = a_in[size_in-1:H];
  assign b_lo = b_in[H-1:0];
  assign b_hi = b_in[size_in-1:H];

  always_comb begin
    z0 = HW'(a_lo) * HW'(b_lo);
    z2 = HW'(a_hi) * HW'(b_hi);
    // Half-sums carry one extra bit; their product fits in M bits exactly.
    sa = M'(a_lo) + M'(a_hi);
    sb = M'(b_lo) + M'(b_hi);
    z1 = sa * sb - M'(z0) - M'(z2);
    product_out = {z2, z0} + (W'(z1) << H);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant among valid requesters, pointer
// moves past the granted index whenever the grant is accepted.
module rr_arbiter
  import karat_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_REQ-1:0] valid_in,
  input  logic               accept_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [ID_W-1:0]    grant_id_out
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid_in;
    pick                     = rr_pick(valid_ext, 32'(ptr_q), NUM_REQ);
    grant_id_out             = ID_W'(pick.idx);
    grant_out                = '0;
    if (pick.found) grant_out[grant_id_out] = 1'b1;
    ptr_d = ptr_q;
    if (accept_in && pick.found) begin
      ptr_d = (grant_id_out == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_out + ID_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end

endmodule

// File: rtl/karat_mult_arbiter.sv
// Shares one karat_mult between NUM_REQ requesters: round-robin grant into S1,
// combinational multiply, registered product in S2 on a backpressured channel.
module karat_mult_arbiter
  import karat_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned SIZE_IN = SIZE_IN_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  input  logic [NUM_REQ-1:0][SIZE_IN-1:0] req_a_in,
  input  logic [NUM_REQ-1:0][SIZE_IN-1:0] req_b_in,
  output logic                            resp_valid_out,
  input  logic                            resp_ready_in,
  output logic [ID_W-1:0]                 resp_id_out,
  output logic [2*SIZE_IN-1:0]            resp_product_out,
  output logic [31:0]                     done_count_out
);

  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_IN-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [2*SIZE_IN-1:0] s2_p_q, s2_p_d;
  logic [ID_W-1:0]      s2_id_q, s2_id_d;
  logic [31:0]          done_q, done_d;

  logic                 s1_adv, s2_adv, found, accept;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic [2*SIZE_IN-1:0] mult_p;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .valid_in     (req_valid_in),
    .accept_in    (accept),
    .grant_out    (grant),
    .grant_id_out (grant_id)
  );

  karat_mult #(
    .size_in (SIZE_IN)
  ) u_mult (
    .a_in        (s1_a_q),
    .b_in        (s1_b_q),
    .product_out (mult_p)
  );

  always_comb begin
    s2_adv        = !s2_valid_q || resp_ready_in;
    s1_adv        = !s1_valid_q || s2_adv;
    found         = |grant;
    accept        = found && s1_adv;
    req_ready_out = grant & {NUM_REQ{s1_adv}};

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (s1_adv) begin
      s1_valid_d = found;
      if (found) begin
        s1_a_d  = req_a_in[grant_id];
        s1_b_d  = req_b_in[grant_id];
        s1_id_d = grant_id;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      // Data only moves with a real product so an idle S2 keeps its last value.
      if (s1_valid_q) begin
        s2_p_d  = mult_p;
        s2_id_d = s1_id_q;
      end
    end

    done_d = done_q;
    if (s2_valid_q && resp_ready_in) done_d = done_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
      done_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
      done_q     <= done_d;
    end
  end

  assign resp_valid_out   = s2_valid_q;
  assign resp_id_out      = s2_id_q;
  assign resp_product_out = s2_p_q;
  assign done_count_out   = done_q;

endmodule

// File: tb/tb_karat_mult_arbiter.sv
// Directed vector table plus hand-written pipeline sequences and a random
// soak with a product scoreboard for karat_mult_arbiter.
module tb_karat_mult_arbiter;
  import karat_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int unsigned    id;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    int unsigned    id;
    logic [2*W-1:0] p;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid, req_ready;
  logic [N-1:0][W-1:0]   req_a, req_b;
  logic                  resp_valid, resp_ready;
  req_id_t               resp_id;
  logic [2*W-1:0]        resp_p;
  logic [31:0]           done;

  int tests = 0;
  int fails = 0;

  vec_t vecs[8];
  exp_t sb_q[$];

  karat_mult_arbiter #(
    .NUM_REQ (N),
    .SIZE_IN (W)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .req_valid_in     (req_valid),
    .req_ready_out    (req_ready),
    .req_a_in         (req_a),
    .req_b_in         (req_b),
    .resp_valid_out   (resp_valid),
    .resp_ready_in    (resp_ready),
    .resp_id_out      (resp_id),
    .resp_product_out (resp_p),
    .done_count_out   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int unsigned n);
    step();
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id]     = v.a;
    req_b[v.id]     = v.b;
    #1 chk("vec_ready", 128'(req_ready), 128'(32'(1) << v.id));
    step();
    req_valid = '0;
    #1 chk("vec_no_early_resp", 128'(resp_valid), 128'(0));
    step();
    #1;
    chk("vec_resp_valid", 128'(resp_valid), 128'(1));
    chk("vec_resp_id", 128'(resp_id), 128'(v.id));
    chk("vec_product", resp_p, v.p);
    step();
    #1 chk("vec_done_count", 128'(done), 128'(n));
  endtask

  // Soak state
  logic [N-1:0]        pending, acc_mask;
  logic [N-1:0][W-1:0] pa, pb;
  int unsigned         waitc[N];
  logic                prev_hold;
  int unsigned         prev_id;
  logic [2*W-1:0]      prev_p;

  function automatic logic [W-1:0] rand_op();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return {$urandom, $urandom};
  endfunction

  task automatic soak_sample();
    exp_t e;
    acc_mask = req_ready & req_valid;
    chk("soak_ready_without_valid", 128'(req_ready & ~req_valid), 128'(0));
    chk("soak_ready_onehot", 128'($countones(req_ready) > 1), 128'(0));
    for (int i = 0; i < int'(N); i++) begin
      if (acc_mask[i]) begin
        e.id = i;
        e.p  = {64'b0, pa[i]} * {64'b0, pb[i]};
        sb_q.push_back(e);
      end else if (pending[i] && acc_mask != '0) begin
        waitc[i]++;
        chk("soak_wait_bound", 128'(waitc[i] > N - 1), 128'(0));
      end
    end
    if (prev_hold) begin
      chk("soak_hold_valid", 128'(resp_valid), 128'(1));
      chk("soak_hold_id", 128'(resp_id), 128'(prev_id));
      chk("soak_hold_product", resp_p, prev_p);
    end
    if (resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("soak_unexpected_resp", 128'(1), 128'(0));
      end else begin
        e = sb_q.pop_front();
        chk("soak_resp_id", 128'(resp_id), 128'(e.id));
        chk("soak_resp_product", resp_p, e.p);
      end
    end
    prev_hold = resp_valid && !resp_ready;
    prev_id   = 32'(resp_id);
    prev_p    = resp_p;
  endtask

  initial begin
    vecs[0] = '{a: 64'd3, b: 64'd5, id: 0, p: 128'd15};
    vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, id: 1,
                p: 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[2] = '{a: 64'd0, b: 64'hFFFF_FFFF_FFFF_FFFF, id: 2, p: 128'd0};
    vecs[3] = '{a: 64'h1_0000_0000, b: 64'h1_0000_0000, id: 3,
                p: 128'h1_0000_0000_0000_0000};
    vecs[4] = '{a: 64'd7, b: 64'd9, id: 2, p: 128'd63};
    vecs[5] = '{a: 64'h1_0000_0001, b: 64'hFFFF_FFFF, id: 0,
                p: 128'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{a: 64'h8000_0000_0000_0000, b: 64'd2, id: 1,
                p: 128'h1_0000_0000_0000_0000};
    vecs[7] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, id: 3,
                p: 128'h1_FFFF_FFFF_FFFF_FFFE};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #2;
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_id", 128'(resp_id), 128'(0));
    chk("rst_resp_product", resp_p, 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ready_idle", 128'(req_ready), 128'(0));
    req_valid = 4'b0100;
    #1 chk("rst_ready_follows_valid", 128'(req_ready), 128'(4'b0100));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one request at a time, last entry is id 3 so the pointer ends at 0.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i + 1);

    // All four continuously valid.
    step();
    for (int i = 0; i < int'(N); i++) begin
      req_a[i] = 64'(i + 10);
      req_b[i] = 64'(i + 100);
    end
    req_valid = '1;
    for (int j = 0; j <= 10; j++) begin
      int unsigned rid;
      if (j == 9) req_valid = '0;
      #1;
      chk("cont_ready", 128'(req_ready), (j < 9) ? 128'(32'(1) << (j % 4)) : 128'(0));
      if (j >= 2) begin
        rid = 32'((j - 2) % 4);
        chk("cont_resp_valid", 128'(resp_valid), 128'(1));
        chk("cont_resp_id", 128'(resp_id), 128'(rid));
        chk("cont_product", resp_p, 128'((rid + 10) * (rid + 100)));
      end else begin
        chk("cont_resp_idle", 128'(resp_valid), 128'(0));
      end
      step();
    end

    // Backpressure: pointer is at 1 after nine accepts starting at 0.
    resp_ready = 1'b0;
    req_a[0] = 64'd5;    req_b[0] = 64'd5;
    req_a[1] = 64'd1000; req_b[1] = 64'd3;
    req_a[2] = 64'd7;    req_b[2] = 64'd7;
    req_a[3] = 64'd2;    req_b[3] = 64'd2;
    req_valid = 4'b0110;
    #1 chk("bp_first_grant", 128'(req_ready), 128'(4'b0010));
    step();
    req_valid = 4'b0100;
    #1;
    chk("bp_second_grant", 128'(req_ready), 128'(4'b0100));
    chk("bp_no_resp_yet", 128'(resp_valid), 128'(0));
    for (int k = 0; k < 2; k++) begin
      step();
      req_valid = 4'b1001;
      #1;
      chk("bp_full_ready", 128'(req_ready), 128'(0));
      chk("bp_hold_valid", 128'(resp_valid), 128'(1));
      chk("bp_hold_id", 128'(resp_id), 128'(1));
      chk("bp_hold_product", resp_p, 128'd3000);
    end
    step();
    resp_ready = 1'b1;
    #1;
    chk("bp_bubble_free_ready", 128'(req_ready), 128'(4'b1000));
    chk("bp_drain_id1", 128'(resp_id), 128'(1));
    step();
    req_valid = 4'b0001;
    #1;
    chk("bp_drain_id2", 128'(resp_id), 128'(2));
    chk("bp_drain_p2", resp_p, 128'd49);
    chk("bp_next_grant", 128'(req_ready), 128'(4'b0001));
    step();
    req_valid = '0;
    #1;
    chk("bp_resp_id3", 128'(resp_id), 128'(3));
    chk("bp_resp_p3", resp_p, 128'd4);
    step();
    #1;
    chk("bp_resp_id0", 128'(resp_id), 128'(0));
    chk("bp_resp_p0", resp_p, 128'd25);
    step();
    #1;
    chk("bp_empty", 128'(resp_valid), 128'(0));
    chk("bp_done_total", 128'(done), 128'(21));

    // Reset with S1 and S2 both occupied.
    resp_ready = 1'b0;
    req_valid  = 4'b0110;
    step();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    #1 chk("mid_rst_pre_valid", 128'(resp_valid), 128'(1));
    #2;
    req_valid = 4'b1001;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("mid_rst_resp_id", 128'(resp_id), 128'(0));
    chk("mid_rst_product", resp_p, 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_ready", 128'(req_ready), 128'(4'b0001));
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1 chk("post_rst_grant0", 128'(req_ready), 128'(4'b0001));
    step();
    req_valid = '0;
    step();
    #1;
    chk("post_rst_resp_valid", 128'(resp_valid), 128'(1));
    chk("post_rst_resp_id", 128'(resp_id), 128'(0));
    chk("post_rst_product", resp_p, 128'd25);
    step();
    #1 chk("post_rst_done", 128'(done), 128'(1));

    // Random soak.
    pending   = '0;
    acc_mask  = '0;
    prev_hold = 1'b0;
    prev_id   = 0;
    prev_p    = '0;
    for (int i = 0; i < int'(N); i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (acc_mask[i]) pending[i] = 1'b0;
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          pa[i]      = rand_op();
          pb[i]      = rand_op();
          waitc[i]   = 0;
        end
      end
      req_valid  = pending;
      req_a      = pa;
      req_b      = pb;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1 soak_sample();
    end
    step();
    pending    = '0;
    req_valid  = '0;
    resp_ready = 1'b1;
    #1 soak_sample();
    for (int k = 0; k < 4; k++) begin
      step();
      #1 soak_sample();
    end
    chk("soak_all_responded", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
